// File: rtl/inst_buffer_if.sv
// Fetch/Dispatch-facing bus of the instruction buffer, plus the packet payload type.
//   inst_buffer_inputs  : up to N packets from Fetch, index 0 oldest
//   instructions_valid  : number of valid inputs (indices 0..k-1)
//   inst_buffer_spots   : free entries advertised to Fetch, capped at N
//   restore_valid       : branch-stack flush request
//   dispatch_packets    : oldest buffered packets, index 0 is the head
//   dispatch_valid      : number of valid dispatch_packets
//   dispatch_accept     : number of packets Dispatch consumes this cycle
package inst_buffer_pkg;
  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   PC;
    logic              taken;
  } fetch_packet_t;
endpackage

interface inst_buffer_if #(
  parameter int unsigned N               = 3,
  parameter int unsigned NUM_SCALAR_BITS = 2
);
  import inst_buffer_pkg::*;

  fetch_packet_t [N-1:0]      inst_buffer_inputs;
  logic [NUM_SCALAR_BITS-1:0] instructions_valid;
  logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots;
  logic                       restore_valid;
  fetch_packet_t [N-1:0]      dispatch_packets;
  logic [NUM_SCALAR_BITS-1:0] dispatch_valid;
  logic [NUM_SCALAR_BITS-1:0] dispatch_accept;

  // Fetch/Dispatch/branch-stack side
  modport master (
    output inst_buffer_inputs, instructions_valid, restore_valid, dispatch_accept,
    input  inst_buffer_spots, dispatch_packets, dispatch_valid
  );

  // Buffer side
  modport slave (
    input  inst_buffer_inputs, instructions_valid, restore_valid, dispatch_accept,
    output inst_buffer_spots, dispatch_packets, dispatch_valid
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer between Fetch and Dispatch.
// Accepts up to N in-order packets per cycle, presents up to N oldest packets,
// retires as many as Dispatch accepts, and flushes on a branch-stack restore.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : inst_buffer_if slave modport (Fetch writes, Dispatch reads, restore)
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned N               = 3,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned NUM_SCALAR_BITS = 2
) (
  input  logic         clock,
  input  logic         reset,
  inst_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NSB   = NUM_SCALAR_BITS;

  fetch_packet_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W-1:0]      w_free;
  logic [NSB-1:0]        w_spots_c;
  logic [NSB-1:0]        w_dvalid_c;
  logic [NSB-1:0]        w_wr;
  logic [NSB-1:0]        w_rd;
  logic                  w_flush;
  fetch_packet_t [N-1:0] w_disp;

  // Space/availability come from the registered count only: no input-to-output path
  always_comb begin
    w_free     = CNT_W'(DEPTH) - r_count;
    w_spots_c  = (w_free  >= CNT_W'(N)) ? NSB'(N) : NSB'(w_free);
    w_dvalid_c = (r_count >= CNT_W'(N)) ? NSB'(N) : NSB'(r_count);
    w_wr       = (bus.instructions_valid < w_spots_c)  ? bus.instructions_valid : w_spots_c;
    w_rd       = (bus.dispatch_accept    < w_dvalid_c) ? bus.dispatch_accept    : w_dvalid_c;
    w_flush    = !reset || bus.restore_valid;
  end

  // Head-relative read window; slots past dispatch_valid drive zero
  always_comb begin
    w_disp = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (NSB'(i) < w_dvalid_c) w_disp[i] = r_mem[r_head + PTR_W'(i)];
    end
  end

  assign bus.inst_buffer_spots = w_spots_c;
  assign bus.dispatch_valid    = w_dvalid_c;
  assign bus.dispatch_packets  = w_disp;

  // Entry storage is never cleared; a flush cycle's writes are dropped
  always_ff @(posedge clock) begin
    if (!w_flush) begin
      for (int i = 0; i < int'(N); i++) begin
        if (NSB'(i) < w_wr) r_mem[r_tail + PTR_W'(i)] <= bus.inst_buffer_inputs[i];
      end
    end
  end

  // Pointers and occupancy; reset and restore both empty the buffer
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_rd);
      r_tail  <= r_tail + PTR_W'(w_wr);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  // Protocol checks; over-requests are clamped by the logic above
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (bus.instructions_valid <= w_spots_c)
        else $warning("inst_buffer: instructions_valid exceeds inst_buffer_spots");
      assert (bus.dispatch_accept <= w_dvalid_c)
        else $warning("inst_buffer: dispatch_accept exceeds dispatch_valid");
      assert (r_count <= CNT_W'(DEPTH))
        else $error("inst_buffer: count exceeds DEPTH");
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer with N=3, DEPTH=8.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int unsigned N     = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NSB   = 2;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fails;

  inst_buffer_if #(.N(N), .NUM_SCALAR_BITS(NSB)) bus ();

  inst_buffer #(.N(N), .DEPTH(DEPTH), .NUM_SCALAR_BITS(NSB)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic fetch_packet_t mk(input logic [31:0] pc);
    fetch_packet_t p;
    p.inst  = {pc[15:0] ^ 16'hA5C3, ~pc[15:0]};
    p.PC    = pc;
    p.taken = pc[2];
    return p;
  endfunction

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive a write of k packets with consecutive PCs starting at pc0
  task automatic drive_wr(input int k, input logic [31:0] pc0);
    bus.instructions_valid = NSB'(k);
    for (int i = 0; i < int'(N); i++) bus.inst_buffer_inputs[i] = mk(pc0 + 32'(4 * i));
  endtask

  task automatic idle();
    bus.instructions_valid = '0;
    bus.dispatch_accept    = '0;
    bus.restore_valid      = 1'b0;
  endtask

  // Check spots, valid, and the first three PCs (0 meaning zero slot where dv excludes it)
  task automatic check_state(input string tag, input int spots, input int dv,
                             input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
    logic [31:0] pcs [3];
    pcs[0] = p0; pcs[1] = p1; pcs[2] = p2;
    check_eq({tag, ".spots"}, 96'(bus.inst_buffer_spots), 96'(spots));
    check_eq({tag, ".dvalid"}, 96'(bus.dispatch_valid), 96'(dv));
    for (int i = 0; i < int'(N); i++) begin
      if (i < dv) check_eq($sformatf("%s.pkt%0d", tag, i), 96'(bus.dispatch_packets[i]), 96'(mk(pcs[i])));
      else        check_eq($sformatf("%s.pkt%0d", tag, i), 96'(bus.dispatch_packets[i]), 96'(0));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    bus.restore_valid = 1'b0;

    // Reset held 2 cycles under random inputs
    for (int c = 0; c < 2; c++) begin
      bus.instructions_valid = NSB'($urandom_range(0, 3));
      bus.dispatch_accept    = NSB'($urandom_range(0, 3));
      bus.restore_valid      = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'(N); i++) bus.inst_buffer_inputs[i] = mk($urandom);
      step();
    end
    check_state("reset", 3, 0, 0, 0, 0);
    reset = 1'b1;
    idle();

    // Fill to full: 3, 3, 2 packets, PCs 0x0..0x1C
    drive_wr(3, 32'h0);  step(); check_state("fill1", 3, 3, 32'h0, 32'h4, 32'h8);
    drive_wr(3, 32'hC);  step(); check_state("fill2", 2, 3, 32'h0, 32'h4, 32'h8);
    drive_wr(2, 32'h18); step(); check_state("full",  0, 3, 32'h0, 32'h4, 32'h8);

    // From full: accept 3, write 0
    idle(); bus.dispatch_accept = 2'd3; step();
    check_state("acc3", 3, 3, 32'hC, 32'h10, 32'h14);

    // Write 3 (0x20 wraps into entry 0) while accepting 3: count stays 5
    drive_wr(3, 32'h20); bus.dispatch_accept = 2'd3; step();
    check_state("wrap", 3, 3, 32'h18, 32'h1C, 32'h20);

    // Bring count to 7, then over-write by 3 with one spot
    bus.dispatch_accept = '0; drive_wr(2, 32'h2C); step();
    check_state("cnt7", 1, 3, 32'h18, 32'h1C, 32'h20);
    drive_wr(3, 32'h34); step();
    check_state("clampw", 0, 3, 32'h18, 32'h1C, 32'h20);

    // Drain: only 0x34 of the clamped write should remain after 0x30
    idle(); bus.dispatch_accept = 2'd3; step();
    check_state("drain1", 3, 3, 32'h24, 32'h28, 32'h2C);
    step();
    check_state("drain2", 3, 2, 32'h30, 32'h34, 0);
    // Over-accept at count 2 retires only 2
    step();
    check_state("clampr", 3, 0, 0, 0, 0);

    // Restore collision at count 5 with write 3 and accept 2
    idle(); drive_wr(3, 32'h40); step();
    drive_wr(2, 32'h4C); step();
    check_state("cnt5", 3, 3, 32'h40, 32'h44, 32'h48);
    drive_wr(3, 32'h60); bus.dispatch_accept = 2'd2; bus.restore_valid = 1'b1; step();
    check_state("restore", 3, 0, 0, 0, 0);
    idle(); drive_wr(1, 32'h100); step();
    check_state("post_rst", 3, 1, 32'h100, 0, 0);

    // Reset together with restore mid-stream, with traffic in flight
    drive_wr(3, 32'h104); step();
    drive_wr(3, 32'h140); bus.dispatch_accept = 2'd1; bus.restore_valid = 1'b1; reset = 1'b0;
    step();
    check_state("rst_prio", 3, 0, 0, 0, 0);
    reset = 1'b1; idle();
    drive_wr(3, 32'h200); step();
    check_state("fresh1", 3, 3, 32'h200, 32'h204, 32'h208);
    drive_wr(3, 32'h20C); step();
    drive_wr(3, 32'h218); step();
    check_state("fresh_full", 0, 3, 32'h200, 32'h204, 32'h208);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
